// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the hazard/debug request sources and the pipeline sequencer.
// Master drives requests and observes stage controls; slave is the sequencer.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             hz_stall;
  logic             hz_flush_idex;
  logic             br_taken;
  logic             md_start;
  logic             halt_instr;
  logic             dbg_run;
  logic             dbg_step;
  logic             dbg_halt;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_m_en;
  logic             ex_m_flush;
  logic             m_wb_en;
  logic             halted;
  logic             step_done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output hz_stall, hz_flush_idex, br_taken, md_start, halt_instr,
           dbg_run, dbg_step, dbg_halt,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_m_en, ex_m_flush, m_wb_en, halted, step_done, cycle_count
  );

  modport slave (
    input  hz_stall, hz_flush_idex, br_taken, md_start, halt_instr,
           dbg_run, dbg_step, dbg_halt,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_m_en, ex_m_flush, m_wb_en, halted, step_done, cycle_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stage-enable/flush controller for the 5-stage pipeline: enables/flushes are same-cycle
// decodes of state and requests; halted, step_done and cycle_count are registered.
module pipeline_sequencer #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_sequencer_if.slave  sq
);

  localparam int MD_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_MD_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [MD_W-1:0]  md_cnt, md_cnt_nxt;
  logic             step_pend, step_pend_nxt;
  logic             halt_pend, halt_pend_nxt;
  logic             step_done, step_done_nxt;
  logic [CNT_W-1:0] cycle_count;

  logic frz;
  logic adv;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_m_en, ex_m_flush, m_wb_en;

  always_comb begin
    state_nxt     = state;
    md_cnt_nxt    = md_cnt;
    step_pend_nxt = step_pend;
    halt_pend_nxt = halt_pend;
    step_done_nxt = 1'b0;
    frz           = 1'b0;
    adv           = 1'b0;

    case (state)
      S_IDLE: begin
        if (sq.dbg_step) begin
          state_nxt = S_STEP;
        end else if (sq.dbg_run) begin
          state_nxt = S_RUN;
        end
      end

      S_RUN, S_STEP: begin
        if (sq.halt_instr) begin
          state_nxt = S_DONE;
        end else if (sq.md_start) begin
          frz           = 1'b1;
          md_cnt_nxt    = MD_INIT;
          step_pend_nxt = (state == S_STEP);
          state_nxt     = S_MD_WAIT;
        end else begin
          adv = 1'b1;
          if (state == S_STEP) begin
            state_nxt     = S_IDLE;
            step_done_nxt = 1'b1;
          end else if (sq.dbg_halt) begin
            state_nxt = S_IDLE;
          end
        end
      end

      S_MD_WAIT: begin
        if (md_cnt != '0) begin
          frz        = 1'b1;
          md_cnt_nxt = md_cnt - 1'b1;
          if (sq.dbg_halt) begin
            halt_pend_nxt = 1'b1;
          end
        end else begin
          // Last cycle of the window: the op's result moves on while the front end resumes.
          adv           = 1'b1;
          step_pend_nxt = 1'b0;
          halt_pend_nxt = 1'b0;
          if (step_pend || halt_pend) begin
            state_nxt     = S_IDLE;
            step_done_nxt = step_pend;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_DONE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_en     = 1'b0;
    ex_m_flush  = 1'b0;
    m_wb_en     = 1'b0;

    if (frz) begin
      ex_m_en    = 1'b1;
      ex_m_flush = 1'b1;
      m_wb_en    = 1'b1;
    end else if (adv) begin
      ex_m_en  = 1'b1;
      m_wb_en  = 1'b1;
      id_ex_en = 1'b1;
      // A front-end stall outranks a taken branch; the branch re-resolves next cycle.
      if (sq.hz_stall || sq.hz_flush_idex) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = sq.br_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      md_cnt      <= '0;
      step_pend   <= 1'b0;
      halt_pend   <= 1'b0;
      step_done   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_nxt;
      md_cnt    <= md_cnt_nxt;
      step_pend <= step_pend_nxt;
      halt_pend <= halt_pend_nxt;
      step_done <= step_done_nxt;
      if ((state == S_RUN || state == S_STEP || state == S_MD_WAIT) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

  assign sq.pc_en       = pc_en;
  assign sq.if_id_en    = if_id_en;
  assign sq.if_id_flush = if_id_flush;
  assign sq.id_ex_en    = id_ex_en;
  assign sq.id_ex_flush = id_ex_flush;
  assign sq.ex_m_en     = ex_m_en;
  assign sq.ex_m_flush  = ex_m_flush;
  assign sq.m_wb_en     = m_wb_en;
  assign sq.halted      = (state == S_IDLE) || (state == S_DONE);
  assign sq.step_done   = step_done;
  assign sq.cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Two sequencers (mul/div latency 4 and 1, narrow cycle counter) driven with the same
// directed and random requests and compared every cycle against a behavioural model.
module tb_pipeline_sequencer;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [7:0] R_STALL = 8'h80;
  localparam logic [7:0] R_FLID  = 8'h40;
  localparam logic [7:0] R_BR    = 8'h20;
  localparam logic [7:0] R_MD    = 8'h10;
  localparam logic [7:0] R_HALTI = 8'h08;
  localparam logic [7:0] R_RUN   = 8'h04;
  localparam logic [7:0] R_STEP  = 8'h02;
  localparam logic [7:0] R_DHALT = 8'h01;

  // Control vector layout: pc, if_id, if_id_flush, id_ex, id_ex_flush, ex_m, ex_m_flush, m_wb.
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_FRZ   = 8'b0000_0111;
  localparam logic [7:0] C_BUB   = 8'b0001_1101;
  localparam logic [7:0] C_BR    = 8'b1111_0101;
  localparam logic [7:0] C_ALL   = 8'b1101_0101;

  logic clk = 1'b0;
  logic reset;
  logic hz_stall, hz_flush_idex, br_taken, md_start, halt_instr, dbg_run, dbg_step, dbg_halt;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(CW)) sq0 ();
  pipeline_sequencer_if #(.CNT_W(CW)) sq1 ();

  pipeline_sequencer #(.MD_LATENCY(4), .CNT_W(CW)) u_seq4 (.clk(clk), .reset(reset), .sq(sq0));
  pipeline_sequencer #(.MD_LATENCY(1), .CNT_W(CW)) u_seq1 (.clk(clk), .reset(reset), .sq(sq1));

  assign sq0.hz_stall = hz_stall;      assign sq1.hz_stall = hz_stall;
  assign sq0.hz_flush_idex = hz_flush_idex; assign sq1.hz_flush_idex = hz_flush_idex;
  assign sq0.br_taken = br_taken;      assign sq1.br_taken = br_taken;
  assign sq0.md_start = md_start;      assign sq1.md_start = md_start;
  assign sq0.halt_instr = halt_instr;  assign sq1.halt_instr = halt_instr;
  assign sq0.dbg_run = dbg_run;        assign sq1.dbg_run = dbg_run;
  assign sq0.dbg_step = dbg_step;      assign sq1.dbg_step = dbg_step;
  assign sq0.dbg_halt = dbg_halt;      assign sq1.dbg_halt = dbg_halt;

  logic [7:0]    obs_ctl    [2];
  logic          obs_halted [2];
  logic          obs_sdone  [2];
  logic [CW-1:0] obs_cyc    [2];

  assign obs_ctl[0] = {sq0.pc_en, sq0.if_id_en, sq0.if_id_flush, sq0.id_ex_en,
                       sq0.id_ex_flush, sq0.ex_m_en, sq0.ex_m_flush, sq0.m_wb_en};
  assign obs_ctl[1] = {sq1.pc_en, sq1.if_id_en, sq1.if_id_flush, sq1.id_ex_en,
                       sq1.id_ex_flush, sq1.ex_m_en, sq1.ex_m_flush, sq1.m_wb_en};
  assign obs_halted[0] = sq0.halted;       assign obs_halted[1] = sq1.halted;
  assign obs_sdone[0]  = sq0.step_done;    assign obs_sdone[1]  = sq1.step_done;
  assign obs_cyc[0]    = sq0.cycle_count;  assign obs_cyc[1]    = sq1.cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int pc_low = 0;

  // Reference model: mode flags plus a remaining-freeze count (-1 when no mul/div is pending).
  int lat    [2] = '{4, 1};
  bit m_run  [2];
  bit m_step [2];
  bit m_done [2];
  int m_left [2];
  bit m_spend[2];
  bit m_hpend[2];
  bit m_sdone[2];
  int m_cyc  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] front_rules();
    if (hz_stall || hz_flush_idex) return C_BUB;
    if (br_taken) return C_BR;
    return C_ALL;
  endfunction

  function automatic logic [7:0] exp_ctl(input int i);
    if (m_done[i]) return C_NONE;
    if (m_left[i] > 0) return C_FRZ;
    if (m_left[i] == 0) return front_rules();
    if (!(m_run[i] || m_step[i])) return C_NONE;
    if (halt_instr) return C_NONE;
    if (md_start) return C_FRZ;
    return front_rules();
  endfunction

  task automatic model_step(input int i);
    bit nd;
    if (reset) begin
      m_run[i] = 0; m_step[i] = 0; m_done[i] = 0; m_left[i] = -1;
      m_spend[i] = 0; m_hpend[i] = 0; m_sdone[i] = 0; m_cyc[i] = 0;
      return;
    end
    nd = 0;
    if ((m_run[i] || m_step[i] || m_left[i] >= 0) && m_cyc[i] < CMAX) m_cyc[i]++;
    if (m_done[i]) begin
      // sticks until reset
    end else if (m_left[i] > 0) begin
      m_left[i]--;
      if (dbg_halt) m_hpend[i] = 1;
    end else if (m_left[i] == 0) begin
      m_left[i] = -1;
      if (m_spend[i] || m_hpend[i]) nd = m_spend[i];
      else m_run[i] = 1;
      m_spend[i] = 0; m_hpend[i] = 0;
    end else if (m_run[i] || m_step[i]) begin
      if (halt_instr) begin
        m_done[i] = 1; m_run[i] = 0; m_step[i] = 0;
      end else if (md_start) begin
        m_left[i] = lat[i] - 1; m_spend[i] = m_step[i]; m_run[i] = 0; m_step[i] = 0;
      end else if (m_step[i]) begin
        m_step[i] = 0; nd = 1;
      end else if (dbg_halt) begin
        m_run[i] = 0;
      end
    end else if (dbg_step) begin
      m_step[i] = 1;
    end else if (dbg_run) begin
      m_run[i] = 1;
    end
    m_sdone[i] = nd;
  endtask

  task automatic run_cycle(input logic r, input logic [7:0] q);
    reset = r;
    {hz_stall, hz_flush_idex, br_taken, md_start, halt_instr, dbg_run, dbg_step, dbg_halt} = q;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ctl[%0d]", i), 32'(obs_ctl[i]), 32'(exp_ctl(i)));
        check($sformatf("halted[%0d]", i), 32'(obs_halted[i]),
              32'(!(m_run[i] || m_step[i] || m_left[i] >= 0)));
        check($sformatf("step_done[%0d]", i), 32'(obs_sdone[i]), 32'(m_sdone[i]));
        check($sformatf("cycle_count[%0d]", i), 32'(obs_cyc[i]), 32'(m_cyc[i]));
      end
    end
    if (obs_ctl[0][7] === 1'b0) pc_low++;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  initial begin
    logic [7:0] q;
    for (int i = 0; i < 2; i++) m_left[i] = -1;

    run_cycle(1'b1, 8'h00);
    chk_en = 1'b1;
    run_cycle(1'b1, 8'h00);
    run_cycle(1'b1, 8'h00);
    check("reset_halted", 32'(sq0.halted), 32'd1);
    check("reset_count", 32'(sq0.cycle_count), 32'd0);

    // Free-run, then stall and taken branch in the same cycle.
    run_cycle(1'b0, R_RUN);
    run_cycle(1'b0, 8'h00);
    run_cycle(1'b0, R_STALL | R_BR);
    run_cycle(1'b0, R_FLID | R_BR);
    run_cycle(1'b0, R_BR);

    // Mul/div held four cycles: four frozen cycles then the front end moves.
    pc_low = 0;
    repeat (4) run_cycle(1'b0, R_MD);
    run_cycle(1'b0, 8'h00);
    check("md_freeze_cycles", 32'(pc_low), 32'd4);

    // Debug halt, single step, step into a mul/div.
    run_cycle(1'b0, R_DHALT);
    run_cycle(1'b0, R_STEP | R_RUN);
    run_cycle(1'b0, 8'h00);
    run_cycle(1'b0, 8'h00);
    run_cycle(1'b0, R_STEP);
    run_cycle(1'b0, R_MD);
    repeat (6) run_cycle(1'b0, 8'h00);

    // Halt retirement, ignored debug, reset; reset in the middle of a mul/div window.
    run_cycle(1'b0, R_RUN);
    run_cycle(1'b0, R_HALTI | R_BR);
    run_cycle(1'b0, R_RUN);
    run_cycle(1'b0, R_STEP);
    run_cycle(1'b1, 8'h00);
    run_cycle(1'b0, R_RUN);
    run_cycle(1'b0, R_MD);
    run_cycle(1'b0, R_DHALT);
    run_cycle(1'b1, 8'h00);
    run_cycle(1'b0, 8'h00);
    run_cycle(1'b0, R_RUN);
    repeat (80) run_cycle(1'b0, 8'h00);

    for (int n = 0; n < 4000; n++) begin
      q = {pct(20), pct(15), pct(25), pct(10), pct(1), pct(10), pct(10), pct(6)};
      run_cycle(pct(1), q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
